// File: rtl/ddr3_user_master.sv
// User-side request/response master for a DDR3 controller with split read/write ports.
// Runs in a single direction (read or write) at a time so responses stay in request order.
module ddr3_user_master #(
  parameter int MAX_OUT = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cal_done,
  input  logic         cal_pass,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [31:0]  req_addr,
  input  logic [127:0] req_wdata,
  input  logic [15:0]  req_wmask,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_write,
  output logic [127:0] rsp_rdata,
  output logic         rd_addr_en,
  output logic [31:0]  rd_addr,
  input  logic         rd_busy,
  input  logic         rd_valid,
  input  logic [127:0] rd_data,
  output logic         rd_en,
  output logic         wr_en,
  output logic         wr_addr_en,
  output logic [31:0]  wr_addr,
  output logic [127:0] wr_data,
  output logic [15:0]  wr_datamask,
  input  logic         wr_busy,
  input  logic         wr_ack
);

  typedef enum logic [1:0] {
    ST_CAL  = 2'd0,
    ST_IDLE = 2'd1,
    ST_RD   = 2'd2,
    ST_WR   = 2'd3
  } state_t;

  localparam logic [3:0] MAX_OUT_C = 4'(MAX_OUT);

  state_t     state_r;
  state_t     state_s;
  logic [3:0] out_cnt_r;
  logic [3:0] ack_cnt_r;
  logic       type_ok_s;
  logic       busy_s;
  logic       accept_s;
  logic       slot_free_s;
  logic       wr_load_s;
  logic       rsp_take_s;
  logic       ack_inc_s;
  logic       addr_unused_s;

  // The low address nibble selects a byte within a 128-bit word and is dropped.
  assign addr_unused_s = ^req_addr[3:0];

  // Request acceptance, read-data pop and response-load qualifiers.
  always_comb begin
    type_ok_s = 1'b0;
    case (state_r)
      ST_IDLE: type_ok_s = 1'b1;
      ST_RD:   type_ok_s = ~req_write;
      ST_WR:   type_ok_s = req_write;
      default: type_ok_s = 1'b0;
    endcase
    busy_s      = req_write ? wr_busy : rd_busy;
    req_ready   = (state_r != ST_CAL) & (out_cnt_r < MAX_OUT_C) & type_ok_s & ~busy_s;
    accept_s    = req_valid & req_ready;
    slot_free_s = ~rsp_valid | rsp_ready;
    rd_en       = rd_valid & slot_free_s & (state_r == ST_RD);
    wr_load_s   = (ack_cnt_r != 4'd0) & (state_r == ST_WR) & slot_free_s;
    rsp_take_s  = rsp_valid & rsp_ready;
    ack_inc_s   = wr_ack & (state_r == ST_WR);
  end

  // Next-state: leave a direction only once every outstanding response is taken.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_CAL: begin
        if (cal_done & cal_pass) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_CAL;
        end
      end
      ST_IDLE: begin
        if (accept_s) begin
          state_s = req_write ? ST_WR : ST_RD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD, ST_WR: begin
        if (~accept_s & (out_cnt_r == 4'd0)) begin
          state_s = ST_IDLE;
        end else begin
          state_s = state_r;
        end
      end
      default: state_s = ST_CAL;
    endcase
  end

  // State register and in-flight / pending-acknowledge counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_CAL;
      out_cnt_r <= 4'd0;
      ack_cnt_r <= 4'd0;
    end else begin
      state_r <= state_s;
      case ({accept_s, rsp_take_s})
        2'b10:   out_cnt_r <= out_cnt_r + 4'd1;
        2'b01:   out_cnt_r <= out_cnt_r - 4'd1;
        default: out_cnt_r <= out_cnt_r;
      endcase
      case ({ack_inc_s, wr_load_s})
        2'b10:   ack_cnt_r <= ack_cnt_r + 4'd1;
        2'b01:   ack_cnt_r <= ack_cnt_r - 4'd1;
        default: ack_cnt_r <= ack_cnt_r;
      endcase
    end
  end

  // Controller command issue, one cycle after the request handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr_en  <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr_en  <= 1'b0;
      rd_addr     <= 32'd0;
      wr_addr     <= 32'd0;
      wr_data     <= 128'd0;
      wr_datamask <= 16'd0;
    end else begin
      rd_addr_en <= accept_s & ~req_write;
      wr_en      <= accept_s & req_write;
      wr_addr_en <= accept_s & req_write;
      if (accept_s & ~req_write) begin
        rd_addr <= {4'b0000, req_addr[31:4]};
      end
      if (accept_s & req_write) begin
        wr_addr     <= {4'b0000, req_addr[31:4]};
        wr_data     <= req_wdata;
        wr_datamask <= req_wmask;
      end
    end
  end

  // Response register: read data or write acknowledge, one per cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= 128'd0;
    end else if (rd_en) begin
      rsp_valid <= 1'b1;
      rsp_write <= 1'b0;
      rsp_rdata <= rd_data;
    end else if (wr_load_s) begin
      rsp_valid <= 1'b1;
      rsp_write <= 1'b1;
    end else if (rsp_take_s) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ddr3_user_master.sv
// Randomized scoreboard bench for ddr3_user_master with a behavioural controller
// and a user-level memory model that predicts every response.
module tb_ddr3_user_master;

  localparam int MAXO = 8;

  logic         clk = 1'b0;
  logic         reset_n, cal_done, cal_pass;
  logic         req_valid, req_ready, req_write;
  logic [31:0]  req_addr;
  logic [127:0] req_wdata;
  logic [15:0]  req_wmask;
  logic         rsp_valid, rsp_ready, rsp_write;
  logic [127:0] rsp_rdata;
  logic         rd_addr_en, rd_busy, rd_valid, rd_en;
  logic [31:0]  rd_addr;
  logic [127:0] rd_data;
  logic         wr_en, wr_addr_en, wr_busy, wr_ack;
  logic [31:0]  wr_addr;
  logic [127:0] wr_data;
  logic [15:0]  wr_datamask;

  always #5 clk = ~clk;

  ddr3_user_master #(.MAX_OUT(MAXO)) dut (
    .clk(clk), .reset_n(reset_n), .cal_done(cal_done), .cal_pass(cal_pass),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rd_addr_en(rd_addr_en), .rd_addr(rd_addr),
    .rd_busy(rd_busy), .rd_valid(rd_valid), .rd_data(rd_data), .rd_en(rd_en),
    .wr_en(wr_en), .wr_addr_en(wr_addr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_datamask(wr_datamask), .wr_busy(wr_busy), .wr_ack(wr_ack)
  );

  typedef struct {
    logic         w;
    logic [127:0] d;
  } exp_t;

  int           checks = 0;
  int           errors = 0;
  exp_t         sb[$];
  logic [127:0] ref_mem[logic [27:0]];
  logic [127:0] ctl_mem[logic [27:0]];
  logic [127:0] rdq_d[$];
  int           rdq_t[$];
  int           ackq[$];
  int           cyc = 0;
  int           acks_sent = 0;
  int           fix_lat = 0;
  bit           rand_mode = 1'b0;
  logic         rsp_force = 1'b0;

  // monitor state
  bit           mon_pend;
  logic         mon_w;
  logic [31:0]  mon_a;
  logic [127:0] mon_d, mon_old;
  logic [15:0]  mon_m;
  int           mon_mixed;
  exp_t         mon_e;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Byte mask convention shared by reference and controller: mask bit 1 keeps the old byte.
  function automatic logic [127:0] merge(input logic [127:0] o, input logic [127:0] n,
                                         input logic [15:0] m);
    logic [127:0] r;
    r = o;
    for (int b = 0; b < 16; b++) if (!m[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic w, input logic [31:0] a, input logic [127:0] d,
                      input logic [15:0] m);
    int   n;
    logic acc;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wmask = m;
    n = 0; acc = 1'b0;
    while (!acc && n < 3000) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk); #1;
      n++;
    end
    req_valid = 1'b0;
    if (!acc) chk("send_timeout", 256'(acc), 256'd1);
  endtask

  task automatic drain();
    int n;
    rsp_force = 1'b1;
    n = 0;
    while (sb.size() > 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) chk("drain_timeout", 256'(sb.size()), 256'd0);
    cycles(4);
  endtask

  task automatic chk_outputs_zero(input string pfx);
    chk({pfx, "_ctrl"}, {req_ready, rsp_valid, rsp_write, rd_addr_en, rd_en, wr_en, wr_addr_en}, 256'd0);
    chk({pfx, "_addr"}, {rsp_rdata, rd_addr, wr_addr}, 256'd0);
    chk({pfx, "_wdata"}, {wr_data, wr_datamask}, 256'd0);
  endtask

  // Behavioural DDR controller: in-order reads with latency, write acks one per cycle.
  initial begin
    int t;
    rd_valid = 1'b0; rd_data = 128'd0; wr_ack = 1'b0;
    rd_busy = 1'b0; wr_busy = 1'b0; rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        rdq_d.delete(); rdq_t.delete(); ackq.delete();
      end else begin
        if (rd_en && rdq_d.size() > 0) begin
          void'(rdq_d.pop_front());
          void'(rdq_t.pop_front());
        end
        if (rd_addr_en) begin
          rdq_d.push_back(ctl_mem.exists(rd_addr[27:0]) ? ctl_mem[rd_addr[27:0]] : 128'd0);
          rdq_t.push_back(cyc + ((fix_lat > 0) ? fix_lat : int'($urandom_range(1, 6))));
        end
        if (wr_en) begin
          ctl_mem[wr_addr[27:0]] = merge(ctl_mem.exists(wr_addr[27:0]) ? ctl_mem[wr_addr[27:0]] : 128'd0,
                                         wr_data, wr_datamask);
          t = cyc + ((fix_lat > 0) ? fix_lat : int'($urandom_range(1, 8)));
          if (ackq.size() > 0 && t <= ackq[$]) t = ackq[$] + 1;
          ackq.push_back(t);
        end
      end
      @(posedge clk); #2;
      rd_valid = (rdq_t.size() > 0) && (rdq_t[0] <= cyc);
      rd_data  = rd_valid ? rdq_d[0] : 128'd0;
      wr_ack   = 1'b0;
      if (ackq.size() > 0 && ackq[0] <= cyc) begin
        wr_ack = 1'b1;
        void'(ackq.pop_front());
        acks_sent++;
      end
      rd_busy   = rand_mode ? ($urandom_range(0, 3) == 0) : 1'b0;
      wr_busy   = rand_mode ? ($urandom_range(0, 3) == 0) : 1'b0;
      rsp_ready = rand_mode ? 1'($urandom_range(0, 1)) : rsp_force;
    end
  end

  // Monitor: command timing, in-flight limit, direction rule and response scoreboard.
  initial begin
    mon_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mon_pend = 1'b0;
        continue;
      end
      if (mon_pend) begin
        if (mon_w) begin
          chk("wr_cmd", {rd_addr_en, wr_en, wr_addr_en}, 256'b011);
          chk("wr_addr", wr_addr, mon_a);
          chk("wr_data", wr_data, mon_d);
          chk("wr_mask", wr_datamask, mon_m);
        end else begin
          chk("rd_cmd", {rd_addr_en, wr_en, wr_addr_en}, 256'b100);
          chk("rd_addr", rd_addr, mon_a);
        end
      end else begin
        chk("no_cmd", {rd_addr_en, wr_en, wr_addr_en}, 256'b000);
      end
      if (req_ready) chk("out_limit", 256'(sb.size() < MAXO), 256'd1);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 256'(rsp_valid), 256'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("rsp_write", 256'(rsp_write), 256'(mon_e.w));
          if (!mon_e.w) chk("rsp_rdata", rsp_rdata, mon_e.d);
        end
      end
      mon_pend = req_valid && req_ready;
      if (mon_pend) begin
        mon_w = req_write; mon_a = {4'h0, req_addr[31:4]};
        mon_d = req_wdata; mon_m = req_wmask;
        mon_mixed = 0;
        foreach (sb[i]) if (sb[i].w != req_write) mon_mixed++;
        chk("direction_rule", 256'(mon_mixed), 256'd0);
        mon_old = ref_mem.exists(req_addr[31:4]) ? ref_mem[req_addr[31:4]] : 128'd0;
        if (req_write) begin
          ref_mem[req_addr[31:4]] = merge(mon_old, req_wdata, req_wmask);
          sb.push_back('{1'b1, 128'd0});
        end else begin
          sb.push_back('{1'b0, mon_old});
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // Directed scenarios followed by a randomized mixed-traffic phase.
  initial begin
    int   n, base;
    logic cur_w;
    reset_n = 1'b0; cal_done = 1'b0; cal_pass = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_wdata = 128'd0; req_wmask = 16'd0;
    #3;
    chk_outputs_zero("reset");
    cal_done = 1'b1;
    cycles(2);
    reset_n = 1'b1;

    // calibration failed: no requests accepted
    repeat (100) begin
      @(negedge clk);
      chk("cal_fail_ready", 256'(req_ready), 256'd0);
    end
    @(posedge clk); #1;
    cal_pass = 1'b1;
    @(negedge clk);
    chk("cal_same_cycle_ready", 256'(req_ready), 256'd0);
    @(negedge clk);
    chk("cal_pass_ready", 256'(req_ready), 256'd1);
    @(posedge clk); #1;

    // single write, fixed ack latency
    fix_lat = 8; rsp_force = 1'b0;
    send(1'b1, 32'h0000_1230, {16{8'hA5}}, 16'h0000);
    n = 0;
    while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
    chk("wr_rsp_valid", 256'(rsp_valid), 256'd1);
    chk("wr_rsp_write", 256'(rsp_write), 256'd1);
    @(posedge clk); #1;
    drain();

    // read back the word just written, then fill the in-flight window
    fix_lat = 2; rsp_force = 1'b0;
    for (int i = 0; i < MAXO; i++) send(1'b0, 32'h0000_1230 + 32'(i * 16), 128'd0, 16'h0);
    fork
      send(1'b0, 32'h0000_2000, 128'd0, 16'h0);
      begin
        repeat (20) begin
          @(negedge clk);
          chk("full_stall", 256'(req_ready), 256'd0);
        end
        @(posedge clk); #1;
        rsp_force = 1'b1;
      end
    join
    drain();

    // read followed immediately by write
    fix_lat = 0; rsp_force = 1'b1;
    send(1'b0, 32'h0000_0040, 128'd0, 16'h0);
    send(1'b1, 32'h0000_0040, {4{32'hDEAD_BEEF}}, 16'h00F0);
    send(1'b0, 32'h0000_0040, 128'd0, 16'h0);
    drain();

    // three acks stacked while the response port is stalled
    fix_lat = 4; rsp_force = 1'b0;
    base = acks_sent;
    for (int i = 0; i < 3; i++) send(1'b1, 32'h0000_0100 + 32'(i * 16), {4{$urandom}}, 16'h0);
    n = 0;
    while (acks_sent < base + 3 && n < 100) begin @(negedge clk); n++; end
    chk("ack_burst_acks", 256'(acks_sent - base), 256'd3);
    cycles(3);
    rsp_force = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("ack_burst_valid", {rsp_valid, rsp_write}, 256'b11);
    end
    @(negedge clk);
    chk("ack_burst_end", 256'(rsp_valid), 256'd0);
    @(posedge clk); #1;
    drain();

    // randomized traffic over a small address window to exercise read-after-write
    fix_lat = 0; rand_mode = 1'b1; cur_w = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) cur_w = ~cur_w;
      send(cur_w, {23'd0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom)},
           {$urandom, $urandom, $urandom, $urandom},
           ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'h0000);
      cycles($urandom_range(0, 2));
    end
    rand_mode = 1'b0;
    drain();

    // reset between clock edges with reads in flight
    fix_lat = 2; rsp_force = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b0, 32'h0000_0300 + 32'(i * 16), 128'd0, 16'h0);
    cycles(6);
    chk("pre_reset_rsp_valid", 256'(rsp_valid), 256'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_outputs_zero("async_reset");
    sb.delete();
    cycles(3);
    reset_n = 1'b1;
    rsp_force = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("no_stale_rsp", 256'(rsp_valid), 256'd0);
    end
    @(posedge clk); #1;
    rsp_force = 1'b0;
    for (int i = 0; i < MAXO; i++) send(1'b0, 32'h0000_0400 + 32'(i * 16), 128'd0, 16'h0);
    repeat (5) begin
      @(negedge clk);
      chk("post_reset_window", 256'(req_ready), 256'd0);
    end
    @(posedge clk); #1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr3_user_master.md
DDR3_USER_MASTER -- requirements
Module: ddr3_user_master

Interface
REQ-001 SHALL have parameter MAX_OUT, default 8: the maximum number of requests in flight (accepted but response not yet taken); range 1..15.
REQ-002 SHALL have ports, clock and reset first:
  clk  in  1  sole clock, all logic on rising edge
  reset_n  in  1  asynchronous, active-low reset
  cal_done  in  1  controller calibration finished
  cal_pass  in  1  controller calibration passed
  req_valid  in  1  upstream request valid
  req_ready  out  1  request accepted when high with req_valid
  req_write  in  1  1=write, 0=read
  req_addr  in  32  byte address, bits [3:0] ignored
  req_wdata  in  128  write data
  req_wmask  in  16  byte mask for write data
  rsp_valid  out  1  response valid
  rsp_ready  in  1  response taken when high with rsp_valid
  rsp_write  out  1  1=write acknowledge, 0=read data
  rsp_rdata  out  128  read data
  rd_addr_en  out  1  read-address strobe to controller
  rd_addr  out  32  controller word address
  rd_busy  in  1  controller cannot take a read address
  rd_valid  in  1  controller read data valid
  rd_data  in  128  controller read data
  rd_en  out  1  pops controller read data
  wr_en  out  1  write strobe
  wr_addr_en  out  1  write-address strobe
  wr_addr  out  32  controller word address
  wr_data  out  128  write data
  wr_datamask  out  16  write byte mask
  wr_busy  in  1  controller cannot take a write
  wr_ack  in  1  one-cycle write-completion pulse

Function
REQ-003 SHALL use states CAL, IDLE, RD, WR; CAL -> IDLE when cal_done & cal_pass are sampled high; cal_done & ~cal_pass SHALL hold CAL indefinitely.
REQ-004 SHALL drive req_ready = ~CAL & out_cnt < MAX_OUT & (IDLE | RD & ~req_write | WR & req_write) & ~(req_write ? wr_busy : rd_busy).
REQ-005 SHALL, on accept in IDLE, move to RD or WR per req_write; a request of the opposite type SHALL stall (req_ready=0) until out_cnt==0, whereupon the state returns to IDLE.
REQ-006 SHALL issue the controller command exactly one cycle after accept: a read pulses rd_addr_en for 1 cycle; a write pulses wr_en and wr_addr_en together for 1 cycle; address = {4'b0, req_addr[31:4]}; wr_data/wr_datamask registered from req_wdata/req_wmask.
REQ-007 SHALL keep out_cnt (4 bits): +1 on request accept, -1 on rsp_valid & rsp_ready, unchanged when both occur in the same cycle.
REQ-008 SHALL drive rd_en = rd_valid & (~rsp_valid | rsp_ready) & state==RD; on rd_valid & rd_en, rsp_rdata <= rd_data, rsp_write <= 0, rsp_valid <= 1 the next cycle.
REQ-009 SHALL count wr_ack pulses in ack_cnt (4 bits, never dropped); when ack_cnt>0, state==WR, and (~rsp_valid | rsp_ready), SHALL load rsp_valid=1, rsp_write=1, with rsp_rdata unchanged, and decrement ack_cnt; a simultaneous increment and decrement leaves it unchanged.
REQ-010 SHALL deassert rsp_valid after a handshake unless a new response loads in the same cycle, giving one response per cycle at full throughput.
REQ-011 SHALL return responses in request order; this follows from the single-direction mode rule plus the in-order behaviour of the controller.
REQ-012 SHALL ignore rd_valid outside RD (rd_en=0) and wr_ack outside WR (not counted).

Reset
REQ-013 SHALL, while reset_n=0, asynchronously force: state=CAL; out_cnt=0; ack_cnt=0; req_ready, rsp_valid, rsp_write, rd_addr_en, rd_en, wr_en, wr_addr_en all 0; rsp_rdata, rd_addr, wr_addr, wr_data, wr_datamask all 0.
REQ-014 SHALL discard all in-flight requests when reset asserts mid-operation; no response is produced for them after release.

Verification
REQ-015 Release reset with cal_done=1, cal_pass=0 -> req_ready=0 for 100 cycles; then set cal_pass=1 -> req_ready=1 one cycle later.
REQ-016 Write req_addr=0x00001230, req_wdata=0xA5..A5 -> next cycle wr_en=wr_addr_en=1, wr_addr=0x123; wr_ack 8 cycles later -> rsp_valid=1, rsp_write=1.
REQ-017 Issue 9 back-to-back reads with rsp_ready=0 -> 8 accepted, req_ready=0 on the 9th; raise rsp_ready -> 8 responses in order, then the 9th is accepted.
REQ-018 Read followed by write -> write held off until the read response handshakes, then issued; rd_addr_en and wr_en never both pending.
REQ-019 3 consecutive wr_ack pulses with rsp_ready=0 -> ack_cnt=3; release rsp_ready -> exactly 3 write responses on consecutive cycles.
REQ-020 Assert reset_n=0 mid-burst between clock edges -> all outputs 0 immediately, without a clock edge; after release, out_cnt=0 and no stale responses appear.
